// File: rtl/mbus_bus_req_ctrl.sv
// rtl/mbus_bus_req_ctrl.sv - local-node bus requester driving the busy handshake
//
// Purpose:
//   Raises a wake-up request while the bus is idle, waits for bus-busy,
//   collects the arbitration verdict, grants the bus to the TX layer and
//   issues the clear-busy pulse that returns the busy controller to idle.
//
// Ports:
//   i_mbus_clk   block clock, all state on posedge
//   i_resetn     asynchronous active-low reset
//   i_tx_req     level, TX layer wants the bus
//   i_tx_done    1-cycle strobe, transaction finished
//   i_bus_busyn  from busy controller, 0 = bus busy
//   i_arb_valid  1-cycle strobe, verdict valid on i_arb_won
//   i_arb_won    1 = this node won arbitration
//   o_req_out    1 = pull bus line to request wake-up
//   o_tx_grant   level, bus owned by this node
//   o_tx_fail    1-cycle pulse, request timeout or active watchdog
//   o_tx_lost    1-cycle pulse, arbitration lost
//   o_clr_busy   clear-busy pulse to busy controller

module mbus_bus_req_ctrl #(
    parameter int CNT_W       = 11,
    parameter int REQ_TIMEOUT = 16,
    parameter int ACT_TIMEOUT = 1024,
    parameter int CLR_PULSE   = 2,
    parameter int BACKOFF     = 4
) (
    input  logic i_mbus_clk,
    input  logic i_resetn,
    input  logic i_tx_req,
    input  logic i_tx_done,
    input  logic i_bus_busyn,
    input  logic i_arb_valid,
    input  logic i_arb_won,
    output logic o_req_out,
    output logic o_tx_grant,
    output logic o_tx_fail,
    output logic o_tx_lost,
    output logic o_clr_busy
);

    // The counter is loaded with N-1 so that a phase lasting N cycles ends
    // on the cycle where the counter reads zero.
    localparam logic [CNT_W-1:0] LD_REQ = CNT_W'(REQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_ACT = CNT_W'(ACT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_CLR = CNT_W'(CLR_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_BCK = CNT_W'(BACKOFF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQUEST   = 3'd1,
        S_ARB       = 3'd2,
        S_ACTIVE    = 3'd3,
        S_RELEASE   = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_BACKOFF   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;
    // Remembers that WAIT_IDLE was entered after a lost/failed attempt,
    // so the exit goes through BACKOFF instead of straight to IDLE.
    logic             r_penalty;
    logic             w_penalty;

    logic w_req_out;
    logic w_tx_grant;
    logic w_tx_fail;
    logic w_tx_lost;
    logic w_clr_busy;

    // State register; outputs are registered from the next-state decode so
    // they change on the same edge as the state.
    always_ff @(posedge i_mbus_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_penalty  <= 1'b0;
            o_req_out  <= 1'b0;
            o_tx_grant <= 1'b0;
            o_tx_fail  <= 1'b0;
            o_tx_lost  <= 1'b0;
            o_clr_busy <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt;
            r_penalty  <= w_penalty;
            o_req_out  <= w_req_out;
            o_tx_grant <= w_tx_grant;
            o_tx_fail  <= w_tx_fail;
            o_tx_lost  <= w_tx_lost;
            o_clr_busy <= w_clr_busy;
        end
    end

    // Next-state and counter logic. The counter saturates at zero.
    always_comb begin
        w_next_state = r_state;
        w_cnt        = (r_cnt != '0) ? (r_cnt - 1'b1) : '0;
        w_penalty    = r_penalty;
        case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (i_tx_req && i_bus_busyn) begin
                    w_next_state = S_REQUEST;
                    w_cnt        = LD_REQ;
                end
            end
            S_REQUEST: begin
                // Bus going busy takes priority over both abort and timeout.
                if (!i_bus_busyn) begin
                    w_next_state = S_ARB;
                end else if (!i_tx_req) begin
                    w_next_state = S_IDLE;
                    w_cnt        = '0;
                end else if (r_cnt == '0) begin
                    w_next_state = S_BACKOFF;
                    w_cnt        = LD_BCK;
                end
            end
            S_ARB: begin
                if (i_arb_valid) begin
                    if (i_arb_won) begin
                        w_next_state = S_ACTIVE;
                        w_cnt        = LD_ACT;
                    end else begin
                        w_next_state = S_WAIT_IDLE;
                        w_penalty    = 1'b1;
                    end
                end else if (i_bus_busyn) begin
                    w_next_state = S_BACKOFF;
                    w_cnt        = LD_BCK;
                end
            end
            S_ACTIVE: begin
                // A completion on the watchdog's last cycle is a clean finish.
                if (i_tx_done) begin
                    w_next_state = S_RELEASE;
                    w_cnt        = LD_CLR;
                    w_penalty    = 1'b0;
                end else if (r_cnt == '0) begin
                    w_next_state = S_RELEASE;
                    w_cnt        = LD_CLR;
                    w_penalty    = 1'b1;
                end
            end
            S_RELEASE: begin
                if (r_cnt == '0) begin
                    w_next_state = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (i_bus_busyn) begin
                    w_penalty = 1'b0;
                    if (r_penalty) begin
                        w_next_state = S_BACKOFF;
                        w_cnt        = LD_BCK;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_BACKOFF: begin
                if (r_cnt == '0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt        = '0;
                w_penalty    = 1'b0;
            end
        endcase
    end

    // Output decode. Event pulses are derived from the transition taken,
    // so fail and lost cannot coincide.
    always_comb begin
        w_req_out  = (w_next_state == S_REQUEST) || (w_next_state == S_ARB);
        w_tx_grant = (w_next_state == S_ACTIVE);
        w_clr_busy = (w_next_state == S_RELEASE);
        w_tx_fail  = (((r_state == S_REQUEST) || (r_state == S_ARB)) &&
                      (w_next_state == S_BACKOFF)) ||
                     ((r_state == S_ACTIVE) && (w_next_state == S_RELEASE) && !i_tx_done);
        w_tx_lost  = (r_state == S_ARB) && (w_next_state == S_WAIT_IDLE);
    end

endmodule

// File: tb/tb_mbus_bus_req_ctrl.sv
// tb/tb_mbus_bus_req_ctrl.sv - self-checking bench for mbus_bus_req_ctrl
module tb_mbus_bus_req_ctrl;

    localparam int REQ_TO = 16;
    localparam int ACT_TO = 1024;
    localparam int CLR_P  = 2;
    localparam int BACK_N = 4;

    logic clk       = 1'b0;
    logic rst_n     = 1'b1;
    logic tx_req    = 1'b0;
    logic tx_done   = 1'b0;
    logic busyn     = 1'b1;
    logic arb_valid = 1'b0;
    logic arb_won   = 1'b0;
    logic req_out, tx_grant, tx_fail, tx_lost, clr_busy;

    int n_cmp = 0;
    int n_err = 0;
    int c_req, c_grant, c_clr, c_fail, c_lost;

    always #5 clk = ~clk;

    mbus_bus_req_ctrl #(
        .CNT_W(11), .REQ_TIMEOUT(REQ_TO), .ACT_TIMEOUT(ACT_TO),
        .CLR_PULSE(CLR_P), .BACKOFF(BACK_N)
    ) dut (
        .i_mbus_clk (clk),
        .i_resetn   (rst_n),
        .i_tx_req   (tx_req),
        .i_tx_done  (tx_done),
        .i_bus_busyn(busyn),
        .i_arb_valid(arb_valid),
        .i_arb_won  (arb_won),
        .o_req_out  (req_out),
        .o_tx_grant (tx_grant),
        .o_tx_fail  (tx_fail),
        .o_tx_lost  (tx_lost),
        .o_clr_busy (clr_busy)
    );

    // Reference model: phase plus the number of cycles already spent in it.
    typedef enum int {M_IDLE, M_REQ, M_ARB, M_ACT, M_REL, M_WAIT, M_BACK} mode_t;
    mode_t m_mode = M_IDLE;
    mode_t m_nxt  = M_IDLE;
    int    m_age  = 0;
    bit    m_pen  = 1'b0;
    bit    e_req = 0, e_grant = 0, e_clr = 0, e_fail = 0, e_lost = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_counts();
        c_req = 0; c_grant = 0; c_clr = 0; c_fail = 0; c_lost = 0;
    endtask

    task automatic go_idle();
        tx_req = 0; tx_done = 0; busyn = 1; arb_valid = 0; arb_won = 0;
        step(10);
    endtask

    task automatic outs_zero(input string nm);
        chk({nm, "_req"},   32'(req_out),  0);
        chk({nm, "_grant"}, 32'(tx_grant), 0);
        chk({nm, "_clr"},   32'(clr_busy), 0);
        chk({nm, "_fail"},  32'(tx_fail),  0);
        chk({nm, "_lost"},  32'(tx_lost),  0);
    endtask

    // Win arbitration, then run ACTIVE to the watchdog limit.
    task automatic active_timeout(input bit done);
        clr_counts();
        tx_req = 1;                              // c0
        step(1); busyn = 0;                      // c1
        step(2); arb_valid = 1; arb_won = 1;     // c3
        step(1); arb_valid = 0; arb_won = 0; tx_req = 0;  // c4 first ACTIVE cycle
        step(ACT_TO - 1);                        // c1027 last ACTIVE cycle
        if (done) tx_done = 1;
        step(1); tx_done = 0;                    // c1028
        chk("wd_fail_pulse", 32'(tx_fail), done ? 0 : 1);
        chk("wd_clr_on", 32'(clr_busy), 1);
        step(4); busyn = 1; tx_req = 1;          // c1032
        step(2);                                 // c1034
        chk("wd_rereq", 32'(req_out), done ? 1 : 0);
        step(5); tx_req = 0;
        step(4);
        chk("wd_grant_cycles", 32'(c_grant), ACT_TO);
        chk("wd_clr_cycles", 32'(c_clr), CLR_P);
        chk("wd_fail_count", 32'(c_fail), done ? 0 : 1);
        chk("wd_lost_count", 32'(c_lost), 0);
    endtask

    initial begin
        clr_counts();
        fork
            // Model update.
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    m_mode = M_IDLE; m_age = 0; m_pen = 0;
                    e_req = 0; e_grant = 0; e_clr = 0; e_fail = 0; e_lost = 0;
                end else begin
                    m_nxt = m_mode; e_fail = 0; e_lost = 0;
                    case (m_mode)
                        M_IDLE: if (tx_req && busyn) m_nxt = M_REQ;
                        M_REQ: begin
                            if (!busyn) m_nxt = M_ARB;
                            else if (!tx_req) m_nxt = M_IDLE;
                            else if (m_age + 1 >= REQ_TO) begin e_fail = 1; m_nxt = M_BACK; end
                        end
                        M_ARB: begin
                            if (arb_valid) begin
                                if (arb_won) m_nxt = M_ACT;
                                else begin e_lost = 1; m_pen = 1; m_nxt = M_WAIT; end
                            end else if (busyn) begin
                                e_fail = 1; m_nxt = M_BACK;
                            end
                        end
                        M_ACT: begin
                            if (tx_done) begin m_pen = 0; m_nxt = M_REL; end
                            else if (m_age + 1 >= ACT_TO) begin e_fail = 1; m_pen = 1; m_nxt = M_REL; end
                        end
                        M_REL: if (m_age + 1 >= CLR_P) m_nxt = M_WAIT;
                        M_WAIT: if (busyn) begin
                            m_nxt = m_pen ? M_BACK : M_IDLE;
                            m_pen = 0;
                        end
                        M_BACK: if (m_age + 1 >= BACK_N) m_nxt = M_IDLE;
                        default: m_nxt = M_IDLE;
                    endcase
                    m_age   = (m_nxt == m_mode) ? m_age + 1 : 0;
                    m_mode  = m_nxt;
                    e_req   = (m_mode == M_REQ) || (m_mode == M_ARB);
                    e_grant = (m_mode == M_ACT);
                    e_clr   = (m_mode == M_REL);
                end
            end
            // Per-cycle compare against the model, away from the active edge.
            forever begin
                @(negedge clk);
                chk("req_out",  32'(req_out),  32'(e_req));
                chk("tx_grant", 32'(tx_grant), 32'(e_grant));
                chk("clr_busy", 32'(clr_busy), 32'(e_clr));
                chk("tx_fail",  32'(tx_fail),  32'(e_fail));
                chk("tx_lost",  32'(tx_lost),  32'(e_lost));
                chk("drive_excl", 32'((32'(req_out) + 32'(tx_grant) + 32'(clr_busy)) <= 1), 1);
                chk("fail_lost_excl", 32'(tx_fail & tx_lost), 0);
                c_req   += 32'(req_out);
                c_grant += 32'(tx_grant);
                c_clr   += 32'(clr_busy);
                c_fail  += 32'(tx_fail);
                c_lost  += 32'(tx_lost);
            end
        join_none

        // Reset state.
        #2 rst_n = 0;
        #1 outs_zero("reset");
        step(3); rst_n = 1;
        go_idle();

        // Normal win: REQ_OUT cycles 1-6, TX_GRANT 7-20, CLR_BUSY 2 cycles.
        clr_counts();
        tx_req = 1;                              // c0
        step(3); busyn = 0;                      // c3
        step(3); arb_valid = 1; arb_won = 1;     // c6
        step(1); arb_valid = 0; arb_won = 0;     // c7
        chk("win_grant_c7", 32'(tx_grant), 1);
        chk("win_req_c7", 32'(req_out), 0);
        step(13); tx_done = 1;                   // c20
        step(1); tx_done = 0; tx_req = 0;        // c21
        chk("win_clr_c21", 32'(clr_busy), 1);
        step(4); busyn = 1;                      // c25
        step(5);
        chk("win_req_cycles", 32'(c_req), 6);
        chk("win_grant_cycles", 32'(c_grant), 14);
        chk("win_clr_cycles", 32'(c_clr), 2);
        chk("win_fail_count", 32'(c_fail), 0);
        chk("win_lost_count", 32'(c_lost), 0);
        go_idle();

        // Request timeout, backoff, re-request.
        clr_counts();
        tx_req = 1;                              // c0
        step(17);                                // c17
        chk("to_fail_c17", 32'(tx_fail), 1);
        step(4);                                 // c21 (idle after backoff)
        chk("to_req_c21", 32'(req_out), 0);
        chk("to_req_cycles", 32'(c_req), REQ_TO);
        chk("to_fail_count", 32'(c_fail), 1);
        step(1);                                 // c22 re-request
        chk("to_rereq_c22", 32'(req_out), 1);
        // Abort in REQUEST before busy.
        clr_counts();
        tx_req = 0;
        step(1);
        chk("abort_req_fall", 32'(req_out), 0);
        step(4);
        chk("abort_req_cycles", 32'(c_req), 1);
        chk("abort_fail_count", 32'(c_fail), 0);
        chk("abort_lost_count", 32'(c_lost), 0);
        go_idle();

        // Lost arbitration.
        clr_counts();
        tx_req = 1;                              // c0
        step(2); busyn = 0;                      // c2
        step(2); arb_valid = 1; arb_won = 0;     // c4
        step(1); arb_valid = 0;                  // c5
        chk("lost_pulse_c5", 32'(tx_lost), 1);
        step(3); busyn = 1;                      // c8
        step(5);                                 // c13
        chk("lost_req_c13", 32'(req_out), 0);
        step(1);                                 // c14
        chk("lost_rereq_c14", 32'(req_out), 1);
        chk("lost_req_cycles", 32'(c_req), 4);
        chk("lost_count", 32'(c_lost), 1);
        chk("lost_grant_cycles", 32'(c_grant), 0);
        chk("lost_clr_cycles", 32'(c_clr), 0);
        chk("lost_fail_count", 32'(c_fail), 0);
        tx_req = 0;
        go_idle();

        // Active watchdog, then TX_DONE coincident with the last cycle.
        active_timeout(1'b0);
        go_idle();
        active_timeout(1'b1);
        go_idle();

        // Reset during ACTIVE.
        tx_req = 1;
        step(1); busyn = 0;
        step(2); arb_valid = 1; arb_won = 1;
        step(1); arb_valid = 0; arb_won = 0;
        step(5);
        chk("rst_act_grant", 32'(tx_grant), 1);
        #2 rst_n = 0;
        #1 outs_zero("rst_act");
        step(2); rst_n = 1; tx_req = 0; busyn = 1;
        step(3);
        outs_zero("rst_act_after");

        // Reset during RELEASE.
        tx_req = 1;
        step(1); busyn = 0;
        step(2); arb_valid = 1; arb_won = 1;
        step(1); arb_valid = 0; arb_won = 0; tx_done = 1;
        step(1); tx_done = 0;
        chk("rst_rel_clr", 32'(clr_busy), 1);
        #2 rst_n = 0;
        #1 outs_zero("rst_rel");
        step(2); rst_n = 1; busyn = 1; tx_req = 1;
        step(1);
        chk("rst_rel_rereq", 32'(req_out), 1);
        go_idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) tx_req = ~tx_req;
            if ($urandom_range(5) == 0) busyn = ~busyn;
            arb_valid = ($urandom_range(4) == 0);
            arb_won   = 1'($urandom_range(1));
            tx_done   = ($urandom_range(29) == 0);
            step(1);
        end
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
